// File: rtl/toggle_pulse_debouncer.sv
// toggle_pulse_debouncer: synchronises and debounces a raw push-button into a one-cycle toggle request
module toggle_pulse_debouncer #(
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_CYCLES   = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic t_pulse,
  output logic btn_level
);
  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Repeat compares against the full count so pulses recur every REPEAT_CYCLES+1 cycles, never back to back
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES);
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sync_q;
  logic             btn_sync;
  assign btn_sync = sync_q[1];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q    <= '0;
      state_q   <= S_LOW;
      cnt_q     <= '0;
      t_pulse   <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      t_pulse <= 1'b0;
      case (state_q)
        S_LOW:
          if (btn_sync) begin
            state_q <= S_RISE;
            cnt_q   <= '0;
          end
        S_RISE:
          if (!btn_sync) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q   <= S_HIGH;
            cnt_q     <= '0;
            btn_level <= 1'b1;
            t_pulse   <= 1'b1;
          end else cnt_q <= cnt_q + 1'b1;
        S_HIGH:
          if (!btn_sync) begin
            state_q <= S_FALL;
            cnt_q   <= '0;
          end else if (REPEAT_EN != 0) begin
            if (cnt_q == REP_LAST) begin
              t_pulse <= 1'b1;
              cnt_q   <= '0;
            end else cnt_q <= cnt_q + 1'b1;
          end
        S_FALL:
          if (btn_sync) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q   <= S_LOW;
            cnt_q     <= '0;
            btn_level <= 1'b0;
          end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= S_LOW;
      endcase
    end
  end
endmodule

// File: tb/tb_toggle_pulse_debouncer.sv
// tb_toggle_pulse_debouncer: directed stimulus checked against a stable-run model of both repeat modes
module tb_toggle_pulse_debouncer;
  localparam int D = 4;
  localparam int R = 8;
  logic clk = 1'b0;
  logic reset_n, btn_raw;
  logic p0, l0, p1, l1;
  int   passed = 0, total = 0;
  logic go = 1'b0;
  always #5 clk = ~clk;

  toggle_pulse_debouncer #(.CNT_W(20), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_CYCLES(R)) u0 (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .t_pulse(p0), .btn_level(l0));
  toggle_pulse_debouncer #(.CNT_W(20), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_CYCLES(R)) u1 (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .t_pulse(p1), .btn_level(l1));

  task automatic check(input string name, input logic got, input logic exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
  endtask

  // Model: the level flips once the synchronised input has differed from it for D+1 consecutive edges;
  // while held high, the repeat instance pulses after R+1 uninterrupted high edges.
  logic [1:0] m_sh;
  logic       m_s, m_prev;
  logic       m_lvl [2];
  logic       m_pul [2];
  int         m_run [2];
  int         m_hold[2];
  always @(posedge clk) begin
    if (!reset_n) begin
      m_sh = 2'b00;
      m_prev = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_lvl[i] = 1'b0; m_pul[i] = 1'b0; m_run[i] = 0; m_hold[i] = 0;
      end
    end else begin
      m_s = m_sh[1];
      m_sh = {m_sh[0], btn_raw};
      for (int i = 0; i < 2; i++) begin
        m_pul[i] = 1'b0;
        if (m_s != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_lvl[i] = m_s; m_run[i] = 0; m_pul[i] = m_s; m_hold[i] = 0;
          end
        end else begin
          m_run[i] = 0;
          if (i == 1 && m_lvl[i]) begin
            if (!m_prev) m_hold[i] = 0;
            else begin
              m_hold[i]++;
              if (m_hold[i] == R + 1) begin
                m_pul[i] = 1'b1; m_hold[i] = 0;
              end
            end
          end
        end
      end
      m_prev = m_s;
    end
  end

  always @(negedge clk) if (go) begin
    check("model_pulse0", p0, m_pul[0]);
    check("model_level0", l0, m_lvl[0]);
    check("model_pulse1", p1, m_pul[1]);
    check("model_level1", l1, m_lvl[1]);
  end

  task automatic step(input logic b);
    btn_raw = b;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    go = 1'b1;
    check("rst_pulse", p0, 1'b0);
    check("rst_level", l0, 1'b0);
    check("rst_pulse_rep", p1, 1'b0);
    reset_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(1'b1);
      check("t1_pulse", p0, i == 7);
      check("t1_level", l0, i >= 7);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0);
      check("t1_release_level", l0, i < 7);
    end
    step(1'b0);
    step(1'b0);
    for (int i = 1; i <= 47; i++) begin
      step(1'b1);
      check("t2_pulse", p0, i == 7);
      check("t2_level", l0, i >= 7);
      check("t5_repeat", p1, i >= 7 && (i - 7) % 9 == 0);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0);
      check("t5_release_pulse", p1, 1'b0);
      check("t5_release_level", l1, i < 7);
    end
    for (int j = 1; j <= 14; j++) begin
      step(j != 4);
      check("t3_bounce_pulse", p0, j == 11);
    end
    for (int j = 1; j <= 12; j++) begin
      step(!(j == 3 || j == 4));
      check("t4_glitch_level", l0, 1'b1);
      check("t4_glitch_pulse", p0, 1'b0);
    end
    for (int j = 1; j <= 8; j++) begin
      step(1'b0);
      check("t4_release_level", l0, j < 7);
      check("t4_release_pulse", p0, 1'b0);
    end
    for (int j = 1; j <= 5; j++) step(1'b1);
    reset_n = 1'b0;
    step(1'b1);
    check("t6_reset_pulse", p0, 1'b0);
    check("t6_reset_level", l0, 1'b0);
    reset_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(1'b1);
      check("t6_redebounce_pulse", p0, i == 7);
    end
    go = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
